// File: rtl/fetch_hazard_if.sv
// Bus between the fetch/hazard sequencer, its instruction memory and the decode stage.
// With STALL_COUNT_EN defined the bus also carries the 16-bit hazard-bubble counter.
interface fetch_hazard_if #(
    parameter int ADDR_W = 10
) ();
    logic              start;
    logic              pause;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       instr_out;
    logic              instr_valid;
    logic              bubble;
    logic              busy;
    logic              done;
    logic [2:0]        state_dbg;
`ifdef STALL_COUNT_EN
    logic [15:0]       stall_count;

    modport master (
        input  start, pause, imem_data,
        output imem_addr, instr_out, instr_valid, bubble, busy, done, state_dbg, stall_count
    );
    modport slave (
        output start, pause, imem_data,
        input  imem_addr, instr_out, instr_valid, bubble, busy, done, state_dbg, stall_count
    );
`else
    modport master (
        input  start, pause, imem_data,
        output imem_addr, instr_out, instr_valid, bubble, busy, done, state_dbg
    );
    modport slave (
        output start, pause, imem_data,
        input  imem_addr, instr_out, instr_valid, bubble, busy, done, state_dbg
    );
`endif
endinterface

// File: rtl/fetch_hazard_sequencer.sv
// Fetches from instruction memory and issues to decode, inserting NOP bubbles on RAW hazards.
// Optional STALL_COUNT_EN adds a saturating count of hazard bubbles (drain NOPs excluded).
module fetch_hazard_sequencer #(
    parameter int          ADDR_W     = 10,
    parameter int          START_ADDR = 0,
    parameter int          LAST_ADDR  = 1023,
    parameter int          HAZ_DEPTH  = 3,
    parameter logic [31:0] NOP_WORD   = 32'h41E00000
) (
    input logic            clk,
    input logic            rst,
    fetch_hazard_if.master bus
);
    localparam logic [ADDR_W-1:0] START_PC   = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(LAST_ADDR);
    localparam int                DC_W       = (HAZ_DEPTH > 1) ? $clog2(HAZ_DEPTH) : 1;
    localparam logic [DC_W-1:0]   DRAIN_LAST = DC_W'(HAZ_DEPTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] cur_pc;
    logic [DC_W-1:0]   drain_cnt;
    logic [HAZ_DEPTH-1:0] sb_v;
    logic [4:0]        sb_reg [HAZ_DEPTH];

    logic [5:0] opcode;
    logic [4:0] rs, rt, rd, dest;
    logic       src0_v, src1_v, dest_v, hazard;
    logic       run_issue, drain_issue, advance, start_accept;

    assign opcode = bus.imem_data[31:26];
    assign rs     = bus.imem_data[25:21];
    assign rt     = bus.imem_data[20:16];
    assign rd     = bus.imem_data[15:11];

    // NOP_WORD carries the load opcode, so it has to be excluded by exact match first.
    always_comb begin
        src0_v = 1'b0;
        src1_v = 1'b0;
        dest_v = 1'b0;
        dest   = rd;
        if (bus.imem_data != NOP_WORD) begin
            case (opcode)
                6'b001111: begin src0_v = 1'b1; src1_v = 1'b1; dest_v = 1'b1; dest = rd; end
                6'b010000: begin src0_v = 1'b1; dest_v = 1'b1; dest = rt; end
                6'b010001: begin src0_v = 1'b1; src1_v = 1'b1; end
                default: ;
            endcase
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_v[i] && ((src0_v && rs == sb_reg[i]) || (src1_v && rt == sb_reg[i])))
                hazard = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (bus.start) state_next = S_PRIME;
            S_PRIME:        if (!bus.pause) state_next = S_RUN;
            S_RUN:          if (advance && cur_pc == LAST_PC) state_next = S_DRAIN;
            S_DRAIN:        if (drain_issue && drain_cnt == DRAIN_LAST) state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    // instr_valid marks one issue slot per cycle with no ready; pause is the only
    // back-pressure and freezes the sequencer at the clock edge where it is high.
    always_comb begin
        run_issue     = 1'b0;
        drain_issue   = 1'b0;
        start_accept  = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state)
            S_IDLE:  start_accept = bus.start;
            S_PRIME: bus.busy = 1'b1;
            S_RUN:   begin bus.busy = 1'b1; run_issue = !bus.pause; end
            S_DRAIN: begin bus.busy = 1'b1; drain_issue = !bus.pause; end
            S_DONE:  begin bus.done = 1'b1; start_accept = bus.start; end
            default: ;
        endcase
        advance       = run_issue && !hazard;
        bus.imem_addr = advance ? cur_pc + ADDR_W'(1) : cur_pc;
    end

    assign bus.state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_pc          <= START_PC;
            drain_cnt       <= '0;
            sb_v            <= '0;
            bus.instr_out   <= NOP_WORD;
            bus.instr_valid <= 1'b0;
            bus.bubble      <= 1'b0;
        end else begin
            bus.instr_valid <= run_issue || drain_issue;
            if (start_accept) begin
                cur_pc    <= START_PC;
                drain_cnt <= '0;
                sb_v      <= '0;
            end
            if (run_issue || drain_issue) begin
                for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                    sb_v[i]   <= sb_v[i-1];
                    sb_reg[i] <= sb_reg[i-1];
                end
                sb_v[0]   <= advance && dest_v;
                sb_reg[0] <= dest;
            end
            if (run_issue) begin
                bus.instr_out <= hazard ? NOP_WORD : bus.imem_data;
                bus.bubble    <= hazard;
                // The last word moves to DRAIN without advancing cur_pc.
                if (advance && cur_pc != LAST_PC) cur_pc <= cur_pc + ADDR_W'(1);
            end
            if (drain_issue) begin
                bus.instr_out <= NOP_WORD;
                bus.bubble    <= 1'b1;
                drain_cnt     <= drain_cnt + DC_W'(1);
            end
        end
    end

`ifdef STALL_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_accept)
            bus.stall_count <= '0;
        else if (run_issue && hazard && bus.stall_count != 16'hFFFF)
            bus.stall_count <= bus.stall_count + 16'd1;
    end
`endif

endmodule
